// File: rtl/pipelined_arith_unit.sv
// Two-stage streaming add/sub/and/concat unit with valid/ready handshakes.
// S1 captures operands, S2 holds the computed result and status flags.
module pipelined_arith_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_ovf,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int H = WIDTH / 2;
   localparam int M = WIDTH - 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       op;
      logic             sat;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             carry;
      logic             zero;
      logic             ovf;
   } s2_t;

   logic             s1_valid_q, s1_valid_d;
   logic             s2_valid_q, s2_valid_d;
   s1_t              s1_q, s1_d;
   s2_t              s2_q, s2_d;
   s2_t              res;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s1_load, s2_load;
   logic             out_hs;
   logic [WIDTH:0]   sum, diff;
   logic             is_add, is_sub, is_and, is_cat;

   always_comb begin
      sum    = {1'b0, s1_q.a} + {1'b0, s1_q.b};
      diff   = {1'b0, s1_q.a} - {1'b0, s1_q.b};
      is_add = (s1_q.op == 2'b00);
      is_sub = (s1_q.op == 2'b01);
      is_and = (s1_q.op == 2'b10);
      is_cat = (s1_q.op == 2'b11);
      res    = '0;
      unique case (1'b1)
         is_add: begin
            res.data  = (s1_q.sat && sum[WIDTH]) ? {WIDTH{1'b1}}
                                                 : sum[M:0];
            res.carry = sum[WIDTH];
            res.ovf   = (s1_q.a[M] == s1_q.b[M]) && (sum[M] != s1_q.a[M]);
         end
         is_sub: begin
            // borrow out of the WIDTH+1 subtraction is exactly a < b
            res.data  = (s1_q.sat && diff[WIDTH]) ? {WIDTH{1'b0}}
                                                  : diff[M:0];
            res.carry = diff[WIDTH];
            res.ovf   = (s1_q.a[M] != s1_q.b[M]) && (diff[M] != s1_q.a[M]);
         end
         is_and: res.data = s1_q.a & s1_q.b;
         is_cat: res.data = {s1_q.a[H-1:0], s1_q.b[H-1:0]};
         default: res = '0;
      endcase
      res.zero = (res.data == {WIDTH{1'b0}});
   end

   always_comb begin
      s2_load    = !s2_valid_q || out_ready;
      s1_load    = !s1_valid_q || s2_load;
      out_hs     = s2_valid_q && out_ready;
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d = '{a: in_a, b: in_b, op: in_op, sat: in_sat};
         end
      end
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_d = res;
         end
      end
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, out_hs};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = s1_load;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_q.data;
   assign out_carry = s2_q.carry;
   assign out_zero  = s2_q.zero;
   assign out_ovf   = s2_q.ovf;
   assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_pipelined_arith_unit.sv
// Directed bench for pipelined_arith_unit: vector table plus
// streaming, stall, counter-wrap and async-reset sequences.
module tb_pipelined_arith_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready, in_ready2;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic [1:0]  in_op = '0;
   logic        in_sat = 1'b0;
   logic        out_valid, out_valid2;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data, out_data2;
   logic        out_carry, out_carry2;
   logic        out_zero, out_zero2;
   logic        out_ovf, out_ovf2;
   logic [15:0] done_cnt;
   logic [1:0]  done_cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_arith_unit #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sat(in_sat),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_carry(out_carry),
      .out_zero(out_zero), .out_ovf(out_ovf),
      .done_cnt(done_cnt)
   );

   pipelined_arith_unit #(.WIDTH(8), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sat(in_sat),
      .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .out_carry(out_carry2),
      .out_zero(out_zero2), .out_ovf(out_ovf2),
      .done_cnt(done_cnt2)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      logic       sat;
      logic [7:0] data;
      logic       carry;
      logic       zero;
      logic       ovf;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_a = v.a;
      in_b = v.b;
      in_op = v.op;
      in_sat = v.sat;
      chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk($sformatf("v%0d_early", idx), out_valid, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", idx), out_valid, 1);
      chk($sformatf("v%0d_data", idx), out_data, v.data);
      chk($sformatf("v%0d_carry", idx), out_carry, v.carry);
      chk($sformatf("v%0d_zero", idx), out_zero, v.zero);
      chk($sformatf("v%0d_ovf", idx), out_ovf, v.ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] held;
      bit         have;
      bit         hs;
      int         acc;
      int         k;

      vecs[0]  = '{8'hF0, 8'h20, 2'b00, 1'b0, 8'h10, 1, 0, 0};
      vecs[1]  = '{8'hF0, 8'h20, 2'b00, 1'b1, 8'hFF, 1, 0, 0};
      vecs[2]  = '{8'h05, 8'h07, 2'b01, 1'b0, 8'hFE, 1, 0, 0};
      vecs[3]  = '{8'h05, 8'h07, 2'b01, 1'b1, 8'h00, 1, 1, 0};
      vecs[4]  = '{8'h80, 8'h01, 2'b01, 1'b0, 8'h7F, 0, 0, 1};
      vecs[5]  = '{8'hA5, 8'h3C, 2'b10, 1'b0, 8'h24, 0, 0, 0};
      vecs[6]  = '{8'hA5, 8'h3C, 2'b11, 1'b0, 8'h5C, 0, 0, 0};
      vecs[7]  = '{8'hA5, 8'h3C, 2'b10, 1'b1, 8'h24, 0, 0, 0};
      vecs[8]  = '{8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 0, 0, 1};
      vecs[9]  = '{8'h7F, 8'h01, 2'b00, 1'b1, 8'h80, 0, 0, 1};
      vecs[10] = '{8'hFF, 8'h01, 2'b00, 1'b0, 8'h00, 1, 1, 0};
      vecs[11] = '{8'h80, 8'h01, 2'b01, 1'b1, 8'h7F, 0, 0, 1};
      vecs[12] = '{8'h12, 8'h34, 2'b11, 1'b1, 8'h24, 0, 0, 0};
      vecs[13] = '{8'h0F, 8'hF0, 2'b10, 1'b0, 8'h00, 0, 1, 0};

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_flags", {out_carry, out_zero, out_ovf}, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
      @(posedge clk);
      #1;
      chk("table_done_cnt", done_cnt, 14);
      chk("table_done_cnt2", done_cnt2, 2);

      do_reset();
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               in_valid = 1'b1;
               in_a = 8'(i);
               in_b = 8'h01;
               in_op = 2'b00;
               in_sat = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 20) begin
               @(negedge clk);
               w++;
            end
            chk("stream_start", (w < 20), 1);
            if (w < 20) begin
               for (int j = 0; j < 8; j++) begin
                  chk($sformatf("stream_valid%0d", j), out_valid, 1);
                  chk($sformatf("stream_data%0d", j), out_data, j + 1);
                  @(negedge clk);
               end
            end
         end
      join
      chk("stream_done_cnt", done_cnt, 8);
      chk("stream_gap", out_valid, 0);

      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_a = 8'h10;
      in_b = 8'h01;
      in_op = 2'b00;
      in_sat = 1'b0;
      acc = 0;
      have = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid) begin
            if (!have) begin
               held = out_data;
               have = 1'b1;
            end else begin
               chk("stall_hold", out_data, held);
            end
         end
         hs = in_ready;
         if (hs) begin
            q.push_back(in_a + in_b);
            acc++;
         end
         @(posedge clk);
         #1;
         if (hs) in_a = in_a + 8'h01;
         else in_b = 8'($urandom_range(2, 9));
         @(negedge clk);
      end
      chk("stall_accepts", acc, 2);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_held_first", held, 8'h11);

      out_ready = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1);
      if (in_ready) q.push_back(in_a + in_b);
      k = 0;
      while (q.size() > 0 && k < 20) begin
         if (out_valid) chk("drain_data", out_data, q.pop_front());
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", q.size(), 0);
      chk("no_dup0", out_valid, 0);
      @(negedge clk);
      chk("no_dup1", out_valid, 0);
      chk("stall_done_cnt", done_cnt, 11);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a = 8'(i);
         in_b = 8'h02;
         in_op = 2'b00;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("wrap_done_cnt2", done_cnt2, 1);
      chk("wrap_done_cnt", done_cnt, 5);

      @(negedge clk);
      in_valid = 1'b1;
      in_a = 8'h01;
      in_b = 8'h01;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_cnt", done_cnt, 0);
      chk("async_rst_cnt2", done_cnt2, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_ready", in_ready, 1);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
